// File: rtl/cskip_seq_adder.sv
// Multi-cycle wide adder: one 4-bit carry-skip slice is stepped across the
// operands a nibble per clock, least-significant nibble first. A start/done
// handshake frames each operation; the result and the count of nibbles whose
// carry took the skip path are held until the next accepted start.
module cskip_seq_adder #(
   parameter int unsigned WIDTH = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [WIDTH-1:0]               a,
   input  logic [WIDTH-1:0]               b,
   input  logic                           cin,
   output logic                           ready,
   output logic                           busy,
   output logic                           done,
   output logic [WIDTH-1:0]               sum,
   output logic                           cout,
   output logic [$clog2(WIDTH/4+1)-1:0]   skip_cnt
);

   localparam int unsigned NIB  = WIDTH / 4;
   localparam int unsigned IdxW = (NIB > 1) ? $clog2(NIB) : 1;
   localparam int unsigned CntW = $clog2(NIB + 1);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   state_e                state_q, state_d;
   logic [WIDTH-1:0]      a_q, a_d;
   logic [WIDTH-1:0]      b_q, b_d;
   logic                  carry_q, carry_d;
   logic [IdxW-1:0]       idx_q, idx_d;
   logic [WIDTH-1:0]      sum_q, sum_d;
   logic                  cout_q, cout_d;
   logic [CntW-1:0]       skip_cnt_q, skip_cnt_d;
   logic                  ready_q, ready_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   // Slice datapath signals.
   logic [IdxW+1:0]       nib_lsb;
   logic [3:0]            a_nib;
   logic [3:0]            b_nib;
   logic [3:0]            prop;
   logic [4:0]            rc;
   logic [3:0]            s_nib;
   logic                  grp_p;
   logic                  nib_cout;

   // Carry-skip slice: 4-bit ripple, with the group carry bypassing the ripple
   // whenever every bit propagates.
   always_comb begin
      nib_lsb = {idx_q, 2'b00};
      a_nib   = a_q[nib_lsb +: 4];
      b_nib   = b_q[nib_lsb +: 4];
      prop    = a_nib ^ b_nib;
      rc      = '0;
      s_nib   = '0;
      rc[0]   = carry_q;
      for (int i = 0; i < 4; i++) begin
         s_nib[i] = prop[i] ^ rc[i];
         rc[i+1]  = (a_nib[i] & b_nib[i]) | (rc[i] & prop[i]);
      end
      grp_p    = &prop;
      nib_cout = grp_p ? carry_q : rc[4];
   end

   // Next-state and registered-output logic for the IDLE/RUN/DONE sequencer.
   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      carry_d    = carry_q;
      idx_d      = idx_q;
      sum_d      = sum_q;
      cout_d     = cout_q;
      skip_cnt_d = skip_cnt_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               a_d        = a;
               b_d        = b;
               carry_d    = cin;
               idx_d      = '0;
               sum_d      = '0;
               cout_d     = 1'b0;
               skip_cnt_d = '0;
               state_d    = StRun;
            end
         end
         StRun: begin
            sum_d[nib_lsb +: 4] = s_nib;
            carry_d             = nib_cout;
            if (grp_p) begin
               skip_cnt_d = skip_cnt_q + CntW'(1);
            end
            if (idx_q == IdxW'(NIB - 1)) begin
               cout_d  = nib_cout;
               state_d = StDone;
            end else begin
               idx_d = idx_q + IdxW'(1);
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Handshake outputs are registered copies of the next-state decode.
      ready_d = (state_d == StIdle);
      busy_d  = (state_d == StRun);
      done_d  = (state_d == StDone);
   end

   // State register with synchronous active-high reset; reset discards any
   // in-flight operation without a done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         a_q        <= '0;
         b_q        <= '0;
         carry_q    <= 1'b0;
         idx_q      <= '0;
         sum_q      <= '0;
         cout_q     <= 1'b0;
         skip_cnt_q <= '0;
         ready_q    <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         carry_q    <= carry_d;
         idx_q      <= idx_d;
         sum_q      <= sum_d;
         cout_q     <= cout_d;
         skip_cnt_q <= skip_cnt_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign ready    = ready_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign sum      = sum_q;
   assign cout     = cout_q;
   assign skip_cnt = skip_cnt_q;

endmodule

// File: tb/tb_cskip_seq_adder.sv
// Directed and randomised bench for cskip_seq_adder at WIDTH=16.
module tb_cskip_seq_adder;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned NIB   = WIDTH / 4;

   logic             clk;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic [2:0]       skip_cnt;

   int n_checks;
   int n_errors;

   cskip_seq_adder #(
      .WIDTH(WIDTH)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .cin     (cin),
      .ready   (ready),
      .busy    (busy),
      .done    (done),
      .sum     (sum),
      .cout    (cout),
      .skip_cnt(skip_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one edge; outputs are then sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Run one operation with hand-computed expectations. If glitch is set, a
   // stray start with a=FFFF is pulsed in the 2nd busy cycle.
   task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic vc, input logic [15:0] esum, input logic ecout,
                         input logic [2:0] eskip, input bit glitch);
      int lat;
      a = va;
      b = vb;
      cin = vc;
      start = 1'b1;
      check_val({tag, ":ready_pre"}, 32'(ready), 32'd1);
      tick();  // accept edge E0
      start = 1'b0;
      a = ~va;
      b = ~vb;
      cin = ~vc;
      check_val({tag, ":busy_e0"}, 32'(busy), 32'd1);
      check_val({tag, ":ready_e0"}, 32'(ready), 32'd0);
      check_val({tag, ":sum_clr"}, 32'(sum), 32'd0);
      lat = 0;
      while (lat < 20) begin
         tick();
         lat++;
         if (glitch) begin
            start = (lat == 1);
            a = (lat == 1) ? 16'hFFFF : ~va;
         end
         if (done) break;
      end
      start = 1'b0;
      check_val({tag, ":latency"}, 32'(lat), 32'(NIB));
      check_val({tag, ":sum"}, 32'(sum), 32'(esum));
      check_val({tag, ":cout"}, 32'(cout), 32'(ecout));
      check_val({tag, ":skip"}, 32'(skip_cnt), 32'(eskip));
      tick();
      check_val({tag, ":ready_post"}, 32'(ready), 32'd1);
      check_val({tag, ":done_post"}, 32'(done), 32'd0);
      check_val({tag, ":sum_hold"}, 32'(sum), 32'(esum));
   endtask

   initial begin
      int done_seen;
      int issued;
      int finished;
      int cyc;
      int last_done;
      logic [15:0] ea;
      logic [15:0] eb;
      logic        ec;
      logic [16:0] ref_full;
      int          ref_skip;

      n_checks = 0;
      n_errors = 0;
      start = 1'b0;
      a = '0;
      b = '0;
      cin = 1'b0;

      // Reset with random inputs and start asserted; reset wins.
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         cin = 1'($urandom);
         start = 1'b1;
         tick();
      end
      check_val("rst:ready", 32'(ready), 32'd1);
      check_val("rst:busy", 32'(busy), 32'd0);
      check_val("rst:done", 32'(done), 32'd0);
      check_val("rst:sum", 32'(sum), 32'd0);
      check_val("rst:cout", 32'(cout), 32'd0);
      check_val("rst:skip", 32'(skip_cnt), 32'd0);
      rst = 1'b0;
      start = 1'b0;
      tick();

      run_op("t1234", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 3'd0, 1'b0);
      run_op("tffff", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 3'd4, 1'b0);
      run_op("tf0f0", 16'hF0F0, 16'h0F0F, 1'b0, 16'hFFFF, 1'b0, 3'd4, 1'b0);
      run_op("t8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 3'd0, 1'b0);
      run_op("tglitch", 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 3'd0, 1'b1);

      // Reset in the 2nd busy cycle discards the operation.
      a = 16'h1111;
      b = 16'h2222;
      cin = 1'b0;
      start = 1'b1;
      tick();  // E0
      start = 1'b0;
      tick();  // E1: 2nd busy cycle
      check_val("mrst:busy_pre", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_val("mrst:ready", 32'(ready), 32'd1);
      check_val("mrst:busy", 32'(busy), 32'd0);
      check_val("mrst:done", 32'(done), 32'd0);
      check_val("mrst:sum", 32'(sum), 32'd0);
      check_val("mrst:cout", 32'(cout), 32'd0);
      check_val("mrst:skip", 32'(skip_cnt), 32'd0);
      done_seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done) done_seen++;
      end
      check_val("mrst:no_done", 32'(done_seen), 32'd0);
      run_op("t0001", 16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 3'd3, 1'b0);

      // Randomised sweep with start held high throughout.
      issued = 0;
      finished = 0;
      last_done = -1;
      ea = 16'($urandom);
      eb = ($urandom_range(0, 3) == 0) ? ~ea : 16'($urandom);
      ec = 1'($urandom);
      a = ea;
      b = eb;
      cin = ec;
      start = 1'b1;
      issued = 1;
      cyc = 0;
      while (finished < 1000 && cyc < 7000) begin
         tick();
         cyc++;
         if (done) begin
            ref_full = {1'b0, ea} + {1'b0, eb} + 17'(ec);
            ref_skip = 0;
            for (int n = 0; n < 4; n++) begin
               if (((ea >> (4 * n)) & 16'hF) == (~(eb >> (4 * n)) & 16'hF)) ref_skip++;
            end
            check_val("rnd:sum", 32'(sum), 32'(ref_full[15:0]));
            check_val("rnd:cout", 32'(cout), 32'(ref_full[16]));
            check_val("rnd:skip", 32'(skip_cnt), 32'(ref_skip));
            if (last_done >= 0) check_val("rnd:period", 32'(cyc - last_done), 32'd6);
            last_done = cyc;
            finished++;
         end
         if (ready) begin
            if (issued < 1000) begin
               ea = 16'($urandom);
               eb = ($urandom_range(0, 3) == 0) ? ~ea : 16'($urandom);
               ec = 1'($urandom);
               a = ea;
               b = eb;
               cin = ec;
               issued++;
            end else begin
               start = 1'b0;
            end
         end else begin
            // Scramble inputs mid-operation; they must not matter.
            a = 16'($urandom);
            b = 16'($urandom);
            cin = 1'($urandom);
         end
      end
      check_val("rnd:completed", 32'(finished), 32'd1000);
      start = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
